// File: rtl/scale_frame_writer.sv
// Frame writer on the sram_clk domain: buffers scaled RGB565 pixels in a FWFT FIFO and
// issues line-aligned burst writes (address + length) to the frame-buffer controller.
module scale_frame_writer #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 24,
    parameter int BURST_MAX  = 16,
    parameter int FIFO_DEPTH = 64
) (
    input  logic                        sram_clk,
    input  logic                        sys_rst,
    input  logic                        frame_start,
    input  logic [11:0]                 t_width,
    input  logic [11:0]                 t_height,
    input  logic [ADDR_W-1:0]           frame_base,
    input  logic [ADDR_W-1:0]           line_stride,
    input  logic [DATA_W-1:0]           pix_data,
    input  logic                        pix_valid,
    output logic                        wr_req,
    output logic [ADDR_W-1:0]           wr_addr,
    output logic [7:0]                  wr_len,
    input  logic                        wr_ack,
    output logic [DATA_W-1:0]           wr_data,
    input  logic                        wr_data_rd,
    output logic                        frame_done,
    output logic                        overflow,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_REQ, S_XFER, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [11:0]       w_q, w_d, h_q, h_d, x_q, x_d, y_q, y_d;
    logic [23:0]       total_q, total_d, in_cnt_q, in_cnt_d;
    logic [ADDR_W-1:0] stride_q, stride_d, line_addr_q, line_addr_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_len_q, wr_len_d, beat_q, beat_d;
    logic              overflow_q, overflow_d, wr_req_q, wr_req_d, done_q, done_d;
    logic              pend_q, pend_d;
    logic [11:0]       pw_q, pw_d, ph_q, ph_d;
    logic [ADDR_W-1:0] pbase_q, pbase_d, pstride_q, pstride_d;

    logic [11:0]       sel_w, sel_h, rem, x_end;
    logic [ADDR_W-1:0] sel_base, sel_stride;
    logic [23:0]       sel_total;
    logic [7:0]        len_c;
    logic              pop, push, drop, can_take, restart;
    logic [PTR_W-1:0]  wr_idx;

    // A frame_start seen now takes precedence over one parked during a burst.
    assign sel_w      = frame_start ? t_width     : pw_q;
    assign sel_h      = frame_start ? t_height    : ph_q;
    assign sel_base   = frame_start ? frame_base  : pbase_q;
    assign sel_stride = frame_start ? line_stride : pstride_q;
    assign sel_total  = 24'(sel_w) * 24'(sel_h);

    assign rem   = w_q - x_q;
    assign len_c = (rem > 12'(BURST_MAX)) ? 8'(BURST_MAX) : rem[7:0];
    assign x_end = x_q + 12'(wr_len_q);
    assign pop   = (state_q == S_XFER) && wr_data_rd && (level_q != '0);

    // NOTE: every signal driven here gets a default first, so no path leaves a value held (no latch).
    always_comb begin
        state_d     = state_q;
        w_d         = w_q;
        h_d         = h_q;
        x_d         = x_q;
        y_d         = y_q;
        total_d     = total_q;
        stride_d    = stride_q;
        line_addr_d = line_addr_q;
        wr_addr_d   = wr_addr_q;
        wr_len_d    = wr_len_q;
        beat_d      = beat_q;
        overflow_d  = overflow_q;
        wr_req_d    = wr_req_q;
        done_d      = 1'b0;
        pend_d      = pend_q;
        pw_d        = pw_q;
        ph_d        = ph_q;
        pbase_d     = pbase_q;
        pstride_d   = pstride_q;
        restart     = 1'b0;
        can_take    = 1'b0;
        push        = 1'b0;
        drop        = 1'b0;
        wr_idx      = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        level_d     = level_q;
        in_cnt_d    = in_cnt_q;

        case (state_q)
            S_IDLE: restart = frame_start;
            S_WAIT: begin
                if (frame_start) begin
                    restart = 1'b1;
                end else if (8'(level_q) >= len_c) begin
                    state_d   = S_REQ;
                    wr_req_d  = 1'b1;
                    wr_addr_d = line_addr_q + ADDR_W'(x_q);
                    wr_len_d  = len_c;
                end
            end
            S_REQ: begin
                if (frame_start) begin
                    restart = 1'b1;
                end else if (wr_ack) begin
                    state_d  = S_XFER;
                    wr_req_d = 1'b0;
                    beat_d   = wr_len_q;
                end
            end
            S_XFER: begin
                if (frame_start) begin
                    pend_d    = 1'b1;
                    pw_d      = t_width;
                    ph_d      = t_height;
                    pbase_d   = frame_base;
                    pstride_d = line_stride;
                end
                if (pop) begin
                    beat_d = beat_q - 8'd1;
                    if (beat_q == 8'd1) begin
                        if (x_end == w_q) begin
                            x_d         = '0;
                            y_d         = y_q + 12'd1;
                            line_addr_d = line_addr_q + stride_q;
                        end else begin
                            x_d = x_end;
                        end
                        if (frame_start || pend_q) begin
                            restart = 1'b1;
                        end else if ((x_end == w_q) && (y_q + 12'd1 == h_q)) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = S_WAIT;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                restart = frame_start;
            end
            default: state_d = S_IDLE;
        endcase

        if (restart) begin
            w_d         = sel_w;
            h_d         = sel_h;
            stride_d    = sel_stride;
            line_addr_d = sel_base;
            total_d     = sel_total;
            x_d         = '0;
            y_d         = '0;
            beat_d      = '0;
            overflow_d  = 1'b0;
            wr_req_d    = 1'b0;
            pend_d      = 1'b0;
            if ((sel_w == '0) || (sel_h == '0)) begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end else begin
                state_d = S_WAIT;
            end
        end

        // The flush on restart happens before this cycle's pixel is accepted into the new frame.
        can_take = pix_valid && (restart || (state_q != S_IDLE)) &&
                   ((restart ? 24'd0 : in_cnt_q) < (restart ? sel_total : total_q));
        push     = can_take && (restart || (level_q != LVL_W'(FIFO_DEPTH)));
        drop     = can_take && !push;
        if (drop) overflow_d = 1'b1;

        if (restart) begin
            wr_idx   = '0;
            rd_ptr_d = '0;
            wr_ptr_d = PTR_W'(push);
            level_d  = LVL_W'(push);
            in_cnt_d = 24'(push);
        end else begin
            rd_ptr_d = rd_ptr_q + PTR_W'(pop);
            wr_ptr_d = wr_ptr_q + PTR_W'(push);
            level_d  = level_q + LVL_W'(push) - LVL_W'(pop);
            in_cnt_d = in_cnt_q + 24'(push);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge sram_clk) begin
        if (sys_rst) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            w_q         <= '0;
            h_q         <= '0;
            x_q         <= '0;
            y_q         <= '0;
            total_q     <= '0;
            in_cnt_q    <= '0;
            stride_q    <= '0;
            line_addr_q <= '0;
            wr_addr_q   <= '0;
            wr_len_q    <= '0;
            beat_q      <= '0;
            overflow_q  <= 1'b0;
            wr_req_q    <= 1'b0;
            done_q      <= 1'b0;
            pend_q      <= 1'b0;
            pw_q        <= '0;
            ph_q        <= '0;
            pbase_q     <= '0;
            pstride_q   <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            w_q         <= w_d;
            h_q         <= h_d;
            x_q         <= x_d;
            y_q         <= y_d;
            total_q     <= total_d;
            in_cnt_q    <= in_cnt_d;
            stride_q    <= stride_d;
            line_addr_q <= line_addr_d;
            wr_addr_q   <= wr_addr_d;
            wr_len_q    <= wr_len_d;
            beat_q      <= beat_d;
            overflow_q  <= overflow_d;
            wr_req_q    <= wr_req_d;
            done_q      <= done_d;
            pend_q      <= pend_d;
            pw_q        <= pw_d;
            ph_q        <= ph_d;
            pbase_q     <= pbase_d;
            pstride_q   <= pstride_d;
        end
    end

    // NOTE: the storage array is not reset; the pointers and level define which words are valid.
    always_ff @(posedge sram_clk) begin
        if (push) fifo_mem[wr_idx] <= pix_data;
    end

    assign wr_data    = (level_q != '0) ? fifo_mem[rd_ptr_q] : '0;
    assign wr_req     = wr_req_q;
    assign wr_addr    = wr_addr_q;
    assign wr_len     = wr_len_q;
    assign frame_done = done_q;
    assign overflow   = overflow_q;
    assign fifo_level = level_q;

endmodule
